// File: rtl/wb_fir_decoder_if.sv
// Wishbone classic bus bundle shared by the upstream port and the three FIR sub-slave ports.
interface wb_fir_decoder_if #(
  parameter int DW = 32
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [3:0]    sel;
  logic [31:0]   adr;
  logic [DW-1:0] dat_w;
  logic          ack;
  logic [DW-1:0] dat_r;

  modport master (output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/wb_fir_decoder.sv
// Wishbone front-end for the FIR user project: decodes one transaction at a time to
// config / stream-in / stream-out sub-slaves, with watchdog and local status register.
module wb_fir_decoder #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = 64
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  wb_fir_decoder_if.slave         wbs,
  wb_fir_decoder_if.master        s0,
  wb_fir_decoder_if.master        s1,
  wb_fir_decoder_if.master        s2
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOCAL, S_DONE} state_t;

  localparam logic [7:0]             WDOG_LAST = 8'(pTIMEOUT - 1);
  localparam logic [pDATA_WIDTH-1:0] DAT_DEAD  = pDATA_WIDTH'(32'hDEAD_BEEF);

  state_t                 state, state_nxt;
  logic [1:0]             tgt_q;
  logic                   we_q;
  logic [3:0]             sel_q;
  logic [pADDR_WIDTH-1:0] adr_q;
  logic [pDATA_WIDTH-1:0] dat_q;
  logic                   stat_q;
  logic [7:0]             wdog;
  logic                   err;
  logic [15:0]            timeout_cnt;
  logic [7:0]             unmap_cnt;

  logic                   req, hit_s0, hit_s1, hit_s2, hit_stat, hit_tgt;
  logic [1:0]             tgt_dec;
  logic                   t_ack, to_evt, clr;
  logic [pDATA_WIDTH-1:0] t_dat, status;
  logic [2:0]             act;

  assign req      = wbs.cyc && wbs.stb && (wbs.adr[31:24] == 8'h30);
  assign hit_s0   = !wbs.adr[7];
  assign hit_s1   = (wbs.adr[7:0] == 8'h80);
  assign hit_s2   = (wbs.adr[7:0] == 8'h84) || (wbs.adr[7:0] == 8'h90);
  assign hit_stat = (wbs.adr[7:0] == 8'hFC);
  assign hit_tgt  = hit_s0 || hit_s1 || hit_s2;
  assign tgt_dec  = hit_s0 ? 2'd0 : (hit_s1 ? 2'd1 : 2'd2);

  assign status = pDATA_WIDTH'({timeout_cnt, unmap_cnt, 7'b0, err});
  assign clr    = stat_q && we_q && sel_q[0] && dat_q[0];

  // Only the registered target, and only while in WAIT, may complete the cycle.
  always_comb begin
    t_ack = 1'b0;
    t_dat = '0;
    case (tgt_q)
      2'd0:    begin t_ack = s0.ack; t_dat = s0.dat_r; end
      2'd1:    begin t_ack = s1.ack; t_dat = s1.dat_r; end
      default: begin t_ack = s2.ack; t_dat = s2.dat_r; end
    endcase
  end

  assign to_evt = (state == S_WAIT) && !t_ack && (wdog == WDOG_LAST);

  always_comb begin
    state_nxt = state;
    wbs.ack   = 1'b0;
    wbs.dat_r = '0;
    case (state)
      S_IDLE: begin
        if (req) state_nxt = hit_tgt ? S_WAIT : S_LOCAL;
      end
      S_WAIT: begin
        if (t_ack) begin
          wbs.ack   = 1'b1;
          wbs.dat_r = we_q ? '0 : t_dat;
          state_nxt = S_DONE;
        end else if (to_evt) begin
          wbs.ack   = 1'b1;
          wbs.dat_r = DAT_DEAD;
          state_nxt = S_DONE;
        end
      end
      S_LOCAL: begin
        wbs.ack   = 1'b1;
        wbs.dat_r = (stat_q && !we_q) ? status : '0;
        state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      tgt_q       <= 2'd0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= '0;
      dat_q       <= '0;
      stat_q      <= 1'b0;
      wdog        <= 8'h0;
      err         <= 1'b0;
      timeout_cnt <= 16'h0;
      unmap_cnt   <= 8'h0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req) begin
        tgt_q  <= tgt_dec;
        we_q   <= wbs.we;
        sel_q  <= wbs.sel;
        adr_q  <= wbs.adr[pADDR_WIDTH-1:0];
        dat_q  <= wbs.dat_w;
        stat_q <= hit_stat;
      end
      if (state == S_WAIT && !t_ack) wdog <= wdog + 8'h1;
      else                           wdog <= 8'h0;
      if (to_evt) begin
        err <= 1'b1;
        if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'h1;
      end
      // A status clear in LOCAL overrides the unmapped-access error of the same cycle.
      if (state == S_LOCAL) begin
        if (clr) begin
          err         <= 1'b0;
          timeout_cnt <= 16'h0;
          unmap_cnt   <= 8'h0;
        end else if (!stat_q) begin
          err <= 1'b1;
          if (unmap_cnt != 8'hFF) unmap_cnt <= unmap_cnt + 8'h1;
        end
      end
    end
  end

  always_comb begin
    act[0] = (state == S_WAIT) && (tgt_q == 2'd0);
    act[1] = (state == S_WAIT) && (tgt_q == 2'd1);
    act[2] = (state == S_WAIT) && (tgt_q == 2'd2);
  end

  assign s0.cyc   = act[0];
  assign s0.stb   = act[0];
  assign s0.we    = act[0] && we_q;
  assign s0.sel   = act[0] ? sel_q : 4'h0;
  assign s0.adr   = act[0] ? 32'(adr_q) : 32'h0;
  assign s0.dat_w = act[0] ? dat_q : '0;

  assign s1.cyc   = act[1];
  assign s1.stb   = act[1];
  assign s1.we    = act[1] && we_q;
  assign s1.sel   = act[1] ? sel_q : 4'h0;
  assign s1.adr   = act[1] ? 32'(adr_q) : 32'h0;
  assign s1.dat_w = act[1] ? dat_q : '0;

  assign s2.cyc   = act[2];
  assign s2.stb   = act[2];
  assign s2.we    = act[2] && we_q;
  assign s2.sel   = act[2] ? sel_q : 4'h0;
  assign s2.adr   = act[2] ? 32'(adr_q) : 32'h0;
  assign s2.dat_w = act[2] ? dat_q : '0;
endmodule

// File: tb/tb_wb_fir_decoder.sv
// Scoreboard bench for wb_fir_decoder: dispatch, ack timing, watchdog, status register, reset.
module tb_wb_fir_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_fir_decoder_if #(.DW(32)) wbs ();
  wb_fir_decoder_if #(.DW(32)) s0 ();
  wb_fir_decoder_if #(.DW(32)) s1 ();
  wb_fir_decoder_if #(.DW(32)) s2 ();

  wb_fir_decoder #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pTIMEOUT(64)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (wbs),
    .s0       (s0),
    .s1       (s1),
    .s2       (s2)
  );

  typedef struct {
    logic [31:0] dat;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] stb_vec();
    return {s2.stb, s1.stb, s0.stb};
  endfunction

  function automatic logic tstb(input int t);
    case (t)
      0:       return s0.stb;
      1:       return s1.stb;
      default: return s2.stb;
    endcase
  endfunction

  function automatic logic tack(input int t);
    case (t)
      0:       return s0.ack;
      1:       return s1.ack;
      default: return s2.ack;
    endcase
  endfunction

  function automatic logic [31:0] tadr(input int t);
    case (t)
      0:       return s0.adr;
      1:       return s1.adr;
      default: return s2.adr;
    endcase
  endfunction

  function automatic logic [31:0] tdat(input int t);
    case (t)
      0:       return s0.dat_w;
      1:       return s1.dat_w;
      default: return s2.dat_w;
    endcase
  endfunction

  function automatic logic [4:0] twesel(input int t);
    case (t)
      0:       return {s0.we, s0.sel};
      1:       return {s1.we, s1.sel};
      default: return {s2.we, s2.sel};
    endcase
  endfunction

  task automatic set_tack(input int t, input logic a, input logic [31:0] d);
    case (t)
      0:       begin s0.ack = a; s0.dat_r = d; end
      1:       begin s1.ack = a; s1.dat_r = d; end
      default: begin s2.ack = a; s2.dat_r = d; end
    endcase
  endtask

  task automatic clear_tacks();
    for (int t = 0; t < 3; t++) set_tack(t, 1'b0, 32'h0);
  endtask

  // tgt 0..2 = sub-slave, 3 = local; ack_after < 0 means the target never acks.
  task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                      input logic [31:0] wdat, input int tgt, input int ack_after,
                      input logic [31:0] rdat, input int spur,
                      input logic [31:0] exp_dat, input int exp_lat);
    exp_t        e;
    exp_t        got_e;
    int          c;
    int          scnt;
    bit          got;
    logic [2:0]  onehot;
    @(posedge clk); #1;
    wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = we;
    wbs.sel = sel;  wbs.adr = adr;  wbs.dat_w = wdat;
    e.dat = exp_dat; e.lat = exp_lat;
    sb.push_back(e);
    c = 0; scnt = 0; got = 1'b0;
    while (!got && c < 300) begin
      @(negedge clk);
      c++;
      clear_tacks();
      if (tgt < 3 && tstb(tgt)) scnt++;
      if (tgt < 3 && ack_after >= 0 && scnt == ack_after + 1) set_tack(tgt, 1'b1, rdat);
      if (spur >= 0 && c == 3) set_tack(spur, 1'b1, 32'hBAD0_BAD0);
      #1;
      if (c == 1) chk("stb_early", 32'(stb_vec()), 32'h0);
      if (c == 2 && tgt == 3) chk("stb_local", 32'(stb_vec()), 32'h0);
      if (c == 2 && tgt < 3) begin
        onehot = 3'b001 << tgt;
        chk("stb_sel", 32'(stb_vec()), 32'(onehot));
        chk("t_adr", tadr(tgt), {20'h0, adr[11:0]});
        chk("t_we_sel", 32'(twesel(tgt)), 32'({we, sel}));
        if (we) chk("t_dat", tdat(tgt), wdat);
      end
      if (wbs.ack) begin
        got   = 1'b1;
        got_e = sb.pop_front();
        chk("rdata", wbs.dat_r, got_e.dat);
        chk("latency", c, got_e.lat);
        if (tgt < 3 && ack_after >= 0) chk("ack_same_cycle", 32'(tack(tgt)), 32'h1);
      end
    end
    if (!got) begin
      chk("ack_bound", c, exp_lat);
      void'(sb.pop_front());
    end
    // Upstream drops stb; any target ack is held into DONE as a late ack.
    @(posedge clk); #1;
    wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
    @(negedge clk); #1;
    chk("done_ack", 32'(wbs.ack), 32'h0);
    chk("done_dat", wbs.dat_r, 32'h0);
    chk("done_stb", 32'(stb_vec()), 32'h0);
    @(posedge clk); #1;
    clear_tacks();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end

  initial begin
    wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
    wbs.sel = 4'h0; wbs.adr = 32'h0; wbs.dat_w = 32'h0;
    clear_tacks();
    #2;
    chk("rst_ack", 32'(wbs.ack), 32'h0);
    chk("rst_dat", wbs.dat_r, 32'h0);
    chk("rst_stb", 32'(stb_vec()), 32'h0);
    chk("rst_s0_adr", s0.adr, 32'h0);
    chk("rst_s0_wesel", 32'(twesel(0)), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    xfer(32'h3000_0010, 1'b1, 4'hF, 32'h5, 0, 3, 32'h0, -1, 32'h0, 5);
    xfer(32'h3000_0084, 1'b0, 4'hF, 32'h0, 2, 0, 32'h1234, -1, 32'h1234, 2);
    xfer(32'h3000_0080, 1'b0, 4'hF, 32'h0, 1, -1, 32'h0, -1, 32'hDEAD_BEEF, 65);
    xfer(32'h3000_00FC, 1'b0, 4'hF, 32'h0, 3, -1, 32'h0, -1, 32'h0001_0001, 2);
    xfer(32'h3000_0040, 1'b0, 4'hF, 32'h0, 0, 2, 32'hCAFE_0040, 1, 32'hCAFE_0040, 4);
    xfer(32'h3000_0090, 1'b1, 4'h3, 32'hA5A5_0090, 2, 1, 32'h0, 0, 32'h0, 3);
    xfer(32'h3000_007F, 1'b0, 4'h1, 32'h0, 0, 0, 32'h0000_007F, -1, 32'h0000_007F, 2);
    // clear, then unmapped accesses build up the counters again
    xfer(32'h3000_00FC, 1'b1, 4'hF, 32'h1, 3, -1, 32'h0, -1, 32'h0, 2);
    xfer(32'h3000_00FC, 1'b0, 4'hF, 32'h0, 3, -1, 32'h0, -1, 32'h0, 2);
    xfer(32'h3000_00A0, 1'b1, 4'hF, 32'h1234_5678, 3, -1, 32'h0, -1, 32'h0, 2);
    xfer(32'h3000_00A0, 1'b0, 4'hF, 32'h0, 3, -1, 32'h0, 2, 32'h0, 2);
    xfer(32'h3000_00FC, 1'b0, 4'hF, 32'h0, 3, -1, 32'h0, -1, 32'h0000_0201, 2);
    xfer(32'h3000_00FC, 1'b1, 4'hE, 32'h1, 3, -1, 32'h0, -1, 32'h0, 2);
    xfer(32'h3000_00FC, 1'b0, 4'hF, 32'h0, 3, -1, 32'h0, -1, 32'h0000_0201, 2);
    xfer(32'h3000_00FC, 1'b1, 4'h1, 32'h1, 3, -1, 32'h0, -1, 32'h0, 2);
    xfer(32'h3000_00FC, 1'b0, 4'hF, 32'h0, 3, -1, 32'h0, -1, 32'h0, 2);

    // request outside the 0x30 region is ignored
    @(posedge clk); #1;
    wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = 1'b0; wbs.adr = 32'h2000_0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("oor_ack", 32'(wbs.ack), 32'h0);
      chk("oor_stb", 32'(stb_vec()), 32'h0);
    end
    @(posedge clk); #1;
    wbs.cyc = 1'b0; wbs.stb = 1'b0;

    // reset in the middle of WAIT
    @(posedge clk); #1;
    wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = 1'b0; wbs.sel = 4'hF; wbs.adr = 32'h3000_0020;
    repeat (3) @(negedge clk);
    #1;
    chk("rw_stb_pre", 32'(s0.stb), 32'h1);
    rst = 1'b1;
    #1;
    chk("rw_stb_drop", 32'(s0.stb), 32'h0);
    chk("rw_ack", 32'(wbs.ack), 32'h0);
    wbs.cyc = 1'b0; wbs.stb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rw_hold_ack", 32'(wbs.ack), 32'h0);
      chk("rw_hold_stb", 32'(stb_vec()), 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(32'h3000_0020, 1'b0, 4'hF, 32'h0, 0, 1, 32'h0000_0077, -1, 32'h0000_0077, 3);
    xfer(32'h3000_00FC, 1'b0, 4'hF, 32'h0, 3, -1, 32'h0, -1, 32'h0, 2);

    chk("sb_empty", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
